// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C receive-only target.
package i2c_pkg;

   localparam int I2C_ADDR_W = 7;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      DATA,
      DATA_ACK,
      IGNORE
   } i2c_rx_state_t;

endpackage

// File: rtl/i2c_target_rx_if.sv
// Bus pins plus receive-side stream between the I2C target and its consumer.
interface i2c_target_rx_if;

   logic       scl_i;
   logic       sda_i;
   logic       sda_oe;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       rx_first;
   logic       busy;
   logic       overflow;

   modport slave (
      input  scl_i,
      input  sda_i,
      input  rx_ready,
      output sda_oe,
      output rx_data,
      output rx_valid,
      output rx_first,
      output busy,
      output overflow
   );

   modport master (
      output scl_i,
      output sda_i,
      output rx_ready,
      input  sda_oe,
      input  rx_data,
      input  rx_valid,
      input  rx_first,
      input  busy,
      input  overflow
   );

endinterface

// File: rtl/i2c_rx_fifo.sv
// Small register FIFO; the head entry is read straight out of the storage flops.
module i2c_rx_fifo #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   output logic             full,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             valid
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             do_wr;
   logic             do_rd;

   assign valid   = (count != '0);
   assign full    = (count == CNT_W'(DEPTH));
   assign do_rd   = rd_en && valid;
   // A pop in the same cycle frees a slot, so a write into a full FIFO is still taken.
   assign do_wr   = wr_en && (!full || do_rd);
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (do_wr) begin
            mem[wr_ptr] <= wr_data;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (do_rd) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({do_wr, do_rd})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/i2c_target_rx.sv
// Write-only I2C target: synchronises the bus, ACKs its own address and
// pushes received data bytes (tagged with a first-byte flag) into a FIFO.
module i2c_target_rx
   import i2c_pkg::*;
#(
   parameter logic [I2C_ADDR_W-1:0] TARGET_ADDR = 7'h42,
   parameter int                    FIFO_DEPTH  = 4,
   parameter int                    SYNC_STAGES = 2
) (
   input logic               clk,
   input logic               rstn,
   i2c_target_rx_if.slave    bus
);

   logic [SYNC_STAGES-1:0] scl_sync;
   logic [SYNC_STAGES-1:0] sda_sync;
   logic                   scl_prev;
   logic                   sda_prev;
   logic                   scl_s;
   logic                   sda_s;
   logic                   scl_rise;
   logic                   scl_fall;
   logic                   start_det;
   logic                   stop_det;

   i2c_rx_state_t state_q;
   i2c_rx_state_t state_d;
   logic [2:0]    bit_cnt_q;
   logic [2:0]    bit_cnt_d;
   logic [6:0]    shift_q;
   logic [6:0]    shift_d;
   logic          ack_phase_q;
   logic          ack_phase_d;
   logic          first_q;
   logic          first_d;
   logic          overflow_q;
   logic          overflow_d;
   logic          sda_oe_q;
   logic          sda_oe_d;
   logic [7:0]    byte_in;

   logic          fifo_wr;
   logic          fifo_full;
   logic          fifo_pop;
   logic          fifo_accept;
   logic [8:0]    fifo_head;

   // Reset presets the synchronisers high so an idle bus produces no edges.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         scl_sync <= '1;
         sda_sync <= '1;
         scl_prev <= 1'b1;
         sda_prev <= 1'b1;
      end else begin
         scl_sync <= {scl_sync[SYNC_STAGES-2:0], bus.scl_i};
         sda_sync <= {sda_sync[SYNC_STAGES-2:0], bus.sda_i};
         scl_prev <= scl_s;
         sda_prev <= sda_s;
      end
   end

   assign scl_s     = scl_sync[SYNC_STAGES-1];
   assign sda_s     = sda_sync[SYNC_STAGES-1];
   assign scl_rise  = scl_s && !scl_prev;
   assign scl_fall  = !scl_s && scl_prev;
   assign start_det = scl_s && sda_prev && !sda_s;
   assign stop_det  = scl_s && !sda_prev && sda_s;

   assign byte_in     = {shift_q, sda_s};
   assign fifo_pop    = bus.rx_valid && bus.rx_ready;
   assign fifo_accept = !fifo_full || fifo_pop;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q     <= IDLE;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         ack_phase_q <= 1'b0;
         first_q     <= 1'b0;
         overflow_q  <= 1'b0;
         sda_oe_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         ack_phase_q <= ack_phase_d;
         first_q     <= first_d;
         overflow_q  <= overflow_d;
         sda_oe_q    <= sda_oe_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      ack_phase_d = ack_phase_q;
      first_d     = first_q;
      overflow_d  = overflow_q;
      fifo_wr     = 1'b0;
      sda_oe_d    = 1'b0;

      if (start_det) begin
         state_d     = ADDR;
         bit_cnt_d   = '0;
         ack_phase_d = 1'b0;
      end else if (stop_det) begin
         state_d     = IDLE;
         bit_cnt_d   = '0;
         ack_phase_d = 1'b0;
      end else begin
         case (state_q)
            ADDR, DATA: begin
               if (scl_rise) begin
                  shift_d   = byte_in[6:0];
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     if (state_q == ADDR) begin
                        if (byte_in[7:1] == TARGET_ADDR && !byte_in[0]) begin
                           state_d = ADDR_ACK;
                           first_d = 1'b1;
                        end else begin
                           state_d = IGNORE;
                        end
                     end else if (fifo_accept) begin
                        fifo_wr = 1'b1;
                        first_d = 1'b0;
                        state_d = DATA_ACK;
                     end else begin
                        overflow_d = 1'b1;
                        state_d    = IGNORE;
                     end
                  end
               end
            end
            // First SCL fall starts driving the ACK, the next one ends it.
            ADDR_ACK, DATA_ACK: begin
               if (scl_fall) begin
                  if (!ack_phase_q) begin
                     ack_phase_d = 1'b1;
                  end else begin
                     ack_phase_d = 1'b0;
                     bit_cnt_d   = '0;
                     state_d     = DATA;
                  end
               end
            end
            IDLE, IGNORE: begin
               state_d = state_q;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end

      sda_oe_d = ack_phase_d && (state_d == ADDR_ACK || state_d == DATA_ACK);
   end

   i2c_rx_fifo #(
      .WIDTH (9),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rstn    (rstn),
      .wr_en   (fifo_wr),
      .wr_data ({first_q, byte_in}),
      .full    (fifo_full),
      .rd_en   (bus.rx_ready),
      .rd_data (fifo_head),
      .valid   (bus.rx_valid)
   );

   assign bus.rx_data  = fifo_head[7:0];
   assign bus.rx_first = fifo_head[8];
   assign bus.sda_oe   = sda_oe_q;
   assign bus.overflow = overflow_q;
   assign bus.busy     = (state_q == ADDR_ACK) || (state_q == DATA) || (state_q == DATA_ACK);

endmodule

// File: tb/tb_i2c_target_rx.sv
// Bench for i2c_target_rx: bit-bangs an I2C master on a wired-AND SDA and
// predicts ACKs, FIFO contents and flags from a queue-based transaction model.
module tb_i2c_target_rx;

   localparam logic [6:0] TARGET = 7'h42;
   localparam int         DEPTH  = 4;
   localparam int         Q      = 8;

   logic       clk = 1'b0;
   logic       rstn;
   logic       master_sda;
   int         total = 0;
   int         bad   = 0;
   logic [8:0] exp_q [$];
   logic [8:0] mon_e;
   logic       model_ovf;
   logic [7:0] tx_bytes [8];
   logic       ack;
   logic [7:0] held_byte;

   i2c_target_rx_if bus_if ();

   assign bus_if.sda_i = master_sda & ~bus_if.sda_oe;

   i2c_target_rx #(
      .TARGET_ADDR (TARGET),
      .FIFO_DEPTH  (DEPTH),
      .SYNC_STAGES (2)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus_if)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Every pop the consumer performs must match the oldest byte the model accepted.
   always @(negedge clk) begin
      if (rstn === 1'b1 && bus_if.rx_valid === 1'b1 && bus_if.rx_ready === 1'b1) begin
         checkOutput("pop_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            checkOutput("pop_data", 32'(bus_if.rx_data), 32'(mon_e[7:0]));
            checkOutput("pop_first", 32'(bus_if.rx_first), 32'(mon_e[8]));
         end
      end
   end

   task automatic waitQ();
      repeat (Q) @(negedge clk);
   endtask

   task automatic setReady(input logic v);
      @(posedge clk);
      #2;
      bus_if.rx_ready = v;
   endtask

   task automatic busStart();
      master_sda = 1'b1;
      waitQ();
      bus_if.scl_i = 1'b1;
      waitQ();
      master_sda = 1'b0;
      waitQ();
      bus_if.scl_i = 1'b0;
      waitQ();
   endtask

   task automatic busStop();
      master_sda = 1'b0;
      waitQ();
      bus_if.scl_i = 1'b1;
      waitQ();
      master_sda = 1'b1;
      waitQ();
   endtask

   task automatic busBit(input logic v);
      master_sda = v;
      waitQ();
      bus_if.scl_i = 1'b1;
      waitQ();
      checkOutput("oe_in_bit", 32'(bus_if.sda_oe), 32'd0);
      bus_if.scl_i = 1'b0;
      waitQ();
   endtask

   task automatic busByte(input logic [7:0] b, output logic acked);
      for (int i = 7; i >= 0; i--) begin
         busBit(b[i]);
      end
      master_sda = 1'b1;
      waitQ();
      bus_if.scl_i = 1'b1;
      waitQ();
      acked = bus_if.sda_oe;
      bus_if.scl_i = 1'b0;
      waitQ();
   endtask

   // One transaction: address byte then n bytes from tx_bytes, optional STOP.
   task automatic applyStimulus(input logic [6:0] addr, input logic rw, input int n, input bit do_stop);
      logic a;
      bit   addressed;
      bit   ignoring;
      bit   accept;
      busStart();
      busByte({addr, rw}, a);
      addressed = (addr == TARGET) && !rw;
      checkOutput("addr_ack", 32'(a), 32'(addressed));
      checkOutput("busy_addr", 32'(bus_if.busy), 32'(addressed));
      ignoring = !addressed;
      for (int i = 0; i < n; i++) begin
         accept = !ignoring && (bus_if.rx_ready || exp_q.size() < DEPTH);
         if (accept) begin
            exp_q.push_back({(i == 0), tx_bytes[i]});
         end else if (!ignoring) begin
            model_ovf = 1'b1;
            ignoring  = 1'b1;
         end
         busByte(tx_bytes[i], a);
         checkOutput("data_ack", 32'(a), 32'(accept));
         checkOutput("busy_data", 32'(bus_if.busy), 32'(!ignoring));
      end
      if (do_stop) begin
         busStop();
         checkOutput("busy_stop", 32'(bus_if.busy), 32'd0);
      end
      checkOutput("overflow", 32'(bus_if.overflow), 32'(model_ovf));
   endtask

   task automatic drain();
      setReady(1'b1);
      for (int i = 0; i < 64 && exp_q.size() != 0; i++) begin
         @(negedge clk);
      end
      repeat (2) @(negedge clk);
      checkOutput("drain_left", 32'(exp_q.size()), 32'd0);
      checkOutput("drain_valid", 32'(bus_if.rx_valid), 32'd0);
   endtask

   initial begin
      #900us;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      rstn            = 1'b0;
      master_sda      = 1'b1;
      bus_if.scl_i    = 1'b1;
      bus_if.rx_ready = 1'b0;
      model_ovf       = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("rst_sda_oe", 32'(bus_if.sda_oe), 32'd0);
      checkOutput("rst_valid", 32'(bus_if.rx_valid), 32'd0);
      checkOutput("rst_data", 32'(bus_if.rx_data), 32'd0);
      checkOutput("rst_first", 32'(bus_if.rx_first), 32'd0);
      checkOutput("rst_busy", 32'(bus_if.busy), 32'd0);
      checkOutput("rst_overflow", 32'(bus_if.overflow), 32'd0);
      rstn = 1'b1;
      waitQ();

      $display("[TB] two bytes to own address, consumer ready");
      setReady(1'b1);
      tx_bytes[0] = 8'hA5;
      tx_bytes[1] = 8'h3C;
      applyStimulus(TARGET, 1'b0, 2, 1'b1);
      drain();

      $display("[TB] wrong address");
      setReady(1'b0);
      tx_bytes[0] = 8'h11;
      applyStimulus(7'h43, 1'b0, 1, 1'b1);
      checkOutput("valid_wrong_addr", 32'(bus_if.rx_valid), 32'd0);

      $display("[TB] read request is refused");
      tx_bytes[0] = 8'($urandom);
      applyStimulus(TARGET, 1'b1, 1, 1'b1);
      checkOutput("valid_read_req", 32'(bus_if.rx_valid), 32'd0);

      $display("[TB] fill the FIFO past its depth");
      for (int i = 0; i < 5; i++) begin
         tx_bytes[i] = 8'(i + 1);
      end
      applyStimulus(TARGET, 1'b0, 5, 1'b1);
      checkOutput("ovf_sticky", 32'(bus_if.overflow), 32'd1);
      drain();

      $display("[TB] repeated START inside a data byte");
      busStart();
      busByte({TARGET, 1'b0}, ack);
      checkOutput("rs_addr_ack", 32'(ack), 32'd1);
      for (int i = 0; i < 4; i++) begin
         busBit(1'($urandom_range(0, 1)));
      end
      tx_bytes[0] = 8'h77;
      applyStimulus(TARGET, 1'b0, 1, 1'b1);
      drain();

      $display("[TB] randomized transactions");
      for (int t = 0; t < 10; t++) begin
         logic [6:0] addr;
         logic       rw;
         int         n;
         addr = ($urandom_range(0, 2) == 0) ? 7'($urandom) : TARGET;
         rw   = ($urandom_range(0, 3) == 0);
         n    = $urandom_range(1, 6);
         for (int i = 0; i < n; i++) begin
            tx_bytes[i] = 8'($urandom);
         end
         setReady(1'($urandom_range(0, 1)));
         applyStimulus(addr, rw, n, ($urandom_range(0, 3) != 0));
      end
      busStop();
      drain();

      $display("[TB] reset during a data ACK");
      setReady(1'b0);
      busStart();
      busByte({TARGET, 1'b0}, ack);
      checkOutput("rr_addr_ack", 32'(ack), 32'd1);
      held_byte = 8'($urandom);
      for (int i = 7; i >= 0; i--) begin
         busBit(held_byte[i]);
      end
      master_sda = 1'b1;
      waitQ();
      checkOutput("oe_data_ack", 32'(bus_if.sda_oe), 32'd1);
      rstn = 1'b0;
      @(negedge clk);
      checkOutput("oe_after_rst", 32'(bus_if.sda_oe), 32'd0);
      checkOutput("valid_after_rst", 32'(bus_if.rx_valid), 32'd0);
      checkOutput("busy_after_rst", 32'(bus_if.busy), 32'd0);
      rstn = 1'b1;
      exp_q.delete();
      model_ovf = 1'b0;
      bus_if.scl_i = 1'b1;
      waitQ();
      bus_if.scl_i = 1'b0;
      waitQ();
      busStop();
      checkOutput("ovf_after_rst", 32'(bus_if.overflow), 32'd0);
      setReady(1'b1);
      for (int i = 0; i < 3; i++) begin
         tx_bytes[i] = 8'($urandom);
      end
      applyStimulus(TARGET, 1'b0, 3, 1'b1);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
